// File: rtl/bitwise_accum_unit.sv
// bitwise_accum_unit: multi-beat bitwise fold engine (AND/OR/XOR/PASS).
// Accepts a valid/ready operand stream, folds each burst into one value
// and presents it on a registered valid/ready result port until consumed.
//
// Optional feature macro: BITWISE_ACCUM_INVERT_EN
//   defined   -> in_op is 3 bits; bit 2 (latched on the first beat) inverts the
//                final result once at HOLD entry (NAND/NOR/XNOR/NOT-PASS).
//   undefined -> in_op is 2 bits, no inversion logic.
//
// Ports:
//   clock, reset_n          clock (rising edge), async active-low reset
//   in_valid/in_ready       operand handshake
//   in_data, in_last, in_op operand, end-of-burst flag, op (first beat only)
//   out_valid/out_ready     result handshake
//   out_data, out_count     folded result, number of beats folded
//   out_trunc               burst ended by MAX_BEATS rather than in_last
module bitwise_accum_unit #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MAX_BEATS = 16,
  parameter int unsigned CNT_W     = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
`ifdef BITWISE_ACCUM_INVERT_EN
  input  logic [2:0]       in_op,
`else
  input  logic [1:0]       in_op,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_trunc
);

`ifdef BITWISE_ACCUM_INVERT_EN
  localparam int unsigned OpW = 3;
`else
  localparam int unsigned OpW = 2;
`endif

  typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OpW-1:0]   op_q, op_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_trunc_q, out_trunc_d;

  logic             first_beat;
  logic             beat_fire;
  logic [OpW-1:0]   op_eff;
  logic [WIDTH-1:0] acc_fold;
  logic [WIDTH-1:0] result_final;
  logic [CNT_W-1:0] cnt_next;
  logic             hit_max;
  logic             burst_end;

  // in_ready depends on state only, never on in_valid.
  assign in_ready   = (state_q != StHold);
  assign first_beat = (state_q == StIdle);
  assign beat_fire  = in_valid & in_ready;

  // The op is captured on the first beat; later beats ignore in_op.
  assign op_eff   = first_beat ? in_op : op_q;
  assign cnt_next = first_beat ? CNT_W'(1) : cnt_q + CNT_W'(1);
  assign hit_max  = (cnt_next == CNT_W'(MAX_BEATS));
  assign burst_end = beat_fire & (in_last | hit_max);

  always_comb begin
    acc_fold = in_data;
    if (!first_beat) begin
      case (op_q[1:0])
        2'b00:   acc_fold = acc_q & in_data;
        2'b01:   acc_fold = acc_q | in_data;
        2'b10:   acc_fold = acc_q ^ in_data;
        default: acc_fold = in_data;
      endcase
    end
  end

  // Inversion is applied once to the final value, never per beat.
`ifdef BITWISE_ACCUM_INVERT_EN
  assign result_final = op_eff[2] ? ~acc_fold : acc_fold;
`else
  assign result_final = acc_fold;
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_trunc_d = out_trunc_q;
    case (state_q)
      StIdle, StAccum: begin
        if (beat_fire) begin
          acc_d = acc_fold;
          cnt_d = cnt_next;
          op_d  = op_eff;
          if (burst_end) begin
            state_d     = StHold;
            out_valid_d = 1'b1;
            out_data_d  = result_final;
            out_count_d = cnt_next;
            out_trunc_d = hit_max & ~in_last;
          end else begin
            state_d = StAccum;
          end
        end
      end
      StHold: begin
        if (out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
          cnt_d       = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      cnt_q       <= '0;
      op_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_trunc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_trunc_q <= out_trunc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_trunc = out_trunc_q;

endmodule

// File: tb/tb_bitwise_accum_unit.sv
// Self-checking bench for bitwise_accum_unit (default parameters).
// Inputs are driven on the falling edge; outputs are sampled on the falling edge.
module tb_bitwise_accum_unit;

  localparam int WIDTH     = 32;
  localparam int MAX_BEATS = 16;
  localparam int CNT_W     = 5;
`ifdef BITWISE_ACCUM_INVERT_EN
  localparam int OPW = 3;
`else
  localparam int OPW = 2;
`endif

  logic             clock;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic [OPW-1:0]   in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_trunc;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] bq[$];

  bitwise_accum_unit #(
    .WIDTH    (WIDTH),
    .MAX_BEATS(MAX_BEATS),
    .CNT_W    (CNT_W)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_op    (in_op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_count(out_count),
    .out_trunc(out_trunc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus only: present one beat for one clock (DUT is ready in every use).
  task automatic drive_beat(input logic [WIDTH-1:0] d, input logic l, input logic [OPW-1:0] op);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    in_op    = op;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (out_data !== '0) begin n_fail++;
      $display("FAIL reset_out_data got=%h exp=0", out_data); end
    n_checks++; if (out_count !== '0) begin n_fail++;
      $display("FAIL reset_out_count got=%0d exp=0", out_count); end
    n_checks++; if (out_trunc !== 1'b0) begin n_fail++;
      $display("FAIL reset_out_trunc got=%b exp=0", out_trunc); end
    reset_n = 1'b1;
    @(negedge clock);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_or_pair();
    drive_beat(32'd188899668, 1'b0, OPW'(1));
    n_checks++; if (out_valid !== 1'b0) begin n_fail++;
      $display("FAIL or_pair_midburst_valid got=%b exp=0", out_valid); end
    drive_beat(32'd1, 1'b1, OPW'(1));
    n_checks++; if (out_valid !== 1'b1) begin n_fail++;
      $display("FAIL or_pair_latency got=%b exp=1", out_valid); end
    n_checks++; if (out_data !== 32'd188899669) begin n_fail++;
      $display("FAIL or_pair_data got=%0d exp=188899669", out_data); end
    n_checks++; if (out_count !== CNT_W'(2)) begin n_fail++;
      $display("FAIL or_pair_count got=%0d exp=2", out_count); end
    n_checks++; if (out_trunc !== 1'b0) begin n_fail++;
      $display("FAIL or_pair_trunc got=%b exp=0", out_trunc); end
    drain();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++;
      $display("FAIL or_pair_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_ops();
    logic [WIDTH-1:0] exp_v [3];
    exp_v[0] = 32'd2568;
    exp_v[1] = 32'd3679;
    exp_v[2] = 32'd1111;
    for (int k = 0; k < 3; k++) begin
      drive_beat(32'd3678, 1'b0, OPW'(k));
      // A different op on beat 2 must be ignored.
      drive_beat(32'd2569, 1'b1, OPW'(3));
      n_checks++; if (out_data !== exp_v[k]) begin n_fail++;
        $display("FAIL ops_op%0d got=%0d exp=%0d", k, out_data, exp_v[k]); end
      drain();
    end
  endtask

  task automatic test_trunc();
    for (int i = 0; i < MAX_BEATS; i++) begin
      n_checks++; if (in_ready !== 1'b1) begin n_fail++;
        $display("FAIL trunc_in_ready_beat%0d got=%b exp=1", i, in_ready); end
      drive_beat(32'd1 << i, 1'b0, OPW'(1));
    end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++;
      $display("FAIL trunc_valid got=%b exp=1", out_valid); end
    n_checks++; if (out_data !== 32'h0000FFFF) begin n_fail++;
      $display("FAIL trunc_data got=%h exp=0000ffff", out_data); end
    n_checks++; if (out_count !== CNT_W'(MAX_BEATS)) begin n_fail++;
      $display("FAIL trunc_count got=%0d exp=%0d", out_count, MAX_BEATS); end
    n_checks++; if (out_trunc !== 1'b1) begin n_fail++;
      $display("FAIL trunc_flag got=%b exp=1", out_trunc); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++;
      $display("FAIL trunc_hold_in_ready got=%b exp=0", in_ready); end
    drain();
  endtask

  task automatic test_backpressure();
    drive_beat(32'hA5A5A5A5, 1'b1, OPW'(0));
    in_valid = 1'b1;
    in_data  = 32'h12345678;
    in_last  = 1'b1;
    in_op    = OPW'(3);
    for (int c = 0; c < 5; c++) begin
      @(posedge clock);
      @(negedge clock);
      n_checks++; if (out_valid !== 1'b1 || out_data !== 32'hA5A5A5A5) begin n_fail++;
        $display("FAIL bp_hold_cycle%0d got valid=%b data=%h exp valid=1 data=a5a5a5a5",
                 c, out_valid, out_data); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++;
        $display("FAIL bp_in_ready_cycle%0d got=%b exp=0", c, in_ready); end
    end
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++;
      $display("FAIL bp_drain got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready); end
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    in_last  = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_data !== 32'h12345678) begin n_fail++;
      $display("FAIL bp_next_burst got valid=%b data=%h exp valid=1 data=12345678",
               out_valid, out_data); end
    n_checks++; if (out_count !== CNT_W'(1)) begin n_fail++;
      $display("FAIL bp_next_count got=%0d exp=1", out_count); end
    drain();
  endtask

  task automatic test_bubbles_reset();
    drive_beat(32'hFFFF0000, 1'b0, OPW'(2));
    repeat (3) @(negedge clock);
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++;
      $display("FAIL bubble_wait got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready); end
    drive_beat(32'h00FFFF00, 1'b1, OPW'(2));
    n_checks++; if (out_data !== 32'hFF00FF00) begin n_fail++;
      $display("FAIL bubble_xor got=%h exp=ff00ff00", out_data); end
    drain();
    // Reset during accumulation.
    drive_beat(32'hDEAD0000, 1'b0, OPW'(1));
    drive_beat(32'h0000BEEF, 1'b0, OPW'(1));
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_data !== '0 || out_count !== '0) begin n_fail++;
      $display("FAIL reset_midburst got valid=%b data=%h count=%0d exp all zero",
               out_valid, out_data, out_count); end
    @(negedge clock);
    reset_n = 1'b1;
    // Reset while holding a result.
    drive_beat(32'h00000055, 1'b1, OPW'(1));
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_data !== '0) begin n_fail++;
      $display("FAIL reset_in_hold got valid=%b data=%h exp valid=0 data=0", out_valid, out_data); end
    @(negedge clock);
    reset_n = 1'b1;
    drive_beat(32'd5, 1'b0, OPW'(1));
    drive_beat(32'd10, 1'b1, OPW'(1));
    n_checks++; if (out_data !== 32'd15 || out_count !== CNT_W'(2)) begin n_fail++;
      $display("FAIL post_reset_burst got data=%0d count=%0d exp data=15 count=2",
               out_data, out_count); end
    drain();
  endtask

`ifdef BITWISE_ACCUM_INVERT_EN
  task automatic test_invert();
    drive_beat(32'd3678, 1'b0, 3'b101);
    drive_beat(32'd2569, 1'b1, 3'b001);
    n_checks++; if (out_data !== 32'hFFFFF1A0) begin n_fail++;
      $display("FAIL invert_nor got=%h exp=fffff1a0", out_data); end
    drain();
    drive_beat(32'h0F0F1234, 1'b1, 3'b100);
    n_checks++; if (out_data !== 32'hF0F0EDCB) begin n_fail++;
      $display("FAIL invert_single got=%h exp=f0f0edcb", out_data); end
    drain();
  endtask
`endif

  // Random bursts folded by a plain loop over the operand list.
  task automatic test_random();
    for (int b = 0; b < 40; b++) begin
      logic [OPW-1:0]   op;
      logic [WIDTH-1:0] exp_d;
      bit               trunc_mode;
      int               n;
      op = OPW'($urandom_range(0, (1 << OPW) - 1));
      trunc_mode = ($urandom_range(0, 4) == 0);
      n = trunc_mode ? MAX_BEATS : $urandom_range(1, MAX_BEATS);
      bq.delete();
      for (int i = 0; i < n; i++) bq.push_back($urandom);
      for (int i = 0; i < n; i++) begin
        if (i > 0 && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clock);
        drive_beat(bq[i], (!trunc_mode && i == n - 1), (i == 0) ? op : OPW'($urandom));
      end
      exp_d = bq[0];
      for (int i = 1; i < n; i++) begin
        case (op[1:0])
          2'b00:   exp_d = exp_d & bq[i];
          2'b01:   exp_d = exp_d | bq[i];
          2'b10:   exp_d = exp_d ^ bq[i];
          default: exp_d = bq[i];
        endcase
      end
`ifdef BITWISE_ACCUM_INVERT_EN
      if (op[2]) exp_d = ~exp_d;
`endif
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== exp_d || out_count !== CNT_W'(n) ||
          out_trunc !== trunc_mode) begin
        n_fail++;
        $display("FAIL rand_burst%0d got v=%b d=%h c=%0d t=%b exp v=1 d=%h c=%0d t=%b",
                 b, out_valid, out_data, out_count, out_trunc, exp_d, n, trunc_mode);
      end
      repeat ($urandom_range(0, 2)) @(negedge clock);
      n_checks++; if (out_valid !== 1'b1 || out_data !== exp_d) begin n_fail++;
        $display("FAIL rand_hold%0d got v=%b d=%h exp v=1 d=%h", b, out_valid, out_data, exp_d); end
      drain();
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    in_op     = '0;
    out_ready = 1'b0;
    @(negedge clock);
    test_reset();
    test_or_pair();
    test_ops();
    test_trunc();
    test_backpressure();
    test_bubbles_reset();
`ifdef BITWISE_ACCUM_INVERT_EN
    test_invert();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bitwise_accum_unit.md
Name: bitwise_accum_unit

Overview:
Parametrised multi-beat bitwise logic engine for the ALU datapath. It generalises the fixed 32-bit two-operand OR to any WIDTH, selectable op (AND/OR/XOR/PASS), and bursts of up to MAX_BEATS operands. It folds a valid/ready input stream into one registered result. The result is then held on a valid/ready output port until it is consumed.

Parameters:
WIDTH, 32, data width of operands and result
MAX_BEATS, 16, maximum operands per burst (>=2); the burst is force-terminated at this count
CNT_W, 5, width of beat counter; must satisfy 2^CNT_W > MAX_BEATS

Ports:
clock  input  1  single clock, rising edge
reset_n  input  1  asynchronous, active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  unit can accept a beat
in_data  input  WIDTH  operand
in_last  input  1  final beat of burst
in_op  input  2 (3 with macro)  00 AND, 01 OR, 10 XOR, 11 PASS (last operand); sampled on first beat only
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_data  output  WIDTH  accumulated result
out_count  output  CNT_W  number of beats folded into result
out_trunc  output  1  burst ended by MAX_BEATS, not in_last

Behaviour:
- Clock and reset: one clock. reset_n is asynchronous and active-low.
- Reset values: state=IDLE, acc=0, cnt=0, op=00, out_valid=0, out_data=0, out_count=0, out_trunc=0. in_ready=1 once reset deasserts.
- Handshake: a beat transfers when in_valid & in_ready. A result transfers when out_valid & out_ready.
- in_ready = (state != HOLD). It is combinational from state only, with no path from in_valid.
- IDLE:
  - On transfer: acc<=in_data, op<=in_op, cnt<=1.
  - If in_last, go to HOLD. A one-beat burst yields out_data=in_data for every op.
  - Otherwise go to ACCUM.
- ACCUM:
  - On transfer: acc<=acc OP in_data (PASS: acc<=in_data), cnt<=cnt+1.
  - If in_last, or cnt+1==MAX_BEATS, go to HOLD.
  - out_trunc=1 only when MAX_BEATS is reached with in_last=0.
  - Without a transfer (in_valid=0), hold state and acc. Bubbles are legal.
- Entering HOLD: out_data<=final acc, out_count<=final cnt, out_valid<=1. Latency is 1 cycle from the last-beat transfer edge to out_valid=1.
- HOLD:
  - in_ready=0.
  - out_data, out_count and out_trunc are stable while out_valid=1 and out_ready=0.
  - On out_ready: out_valid<=0, go to IDLE, cnt<=0.
  - A new burst may start in the cycle after the drain (no same-cycle accept).
- in_op is ignored on non-first beats. The op is fixed for the whole burst.
- Arithmetic: pure bitwise, WIDTH bits, no carries. The counter never wraps; MAX_BEATS termination bounds it.
- Async reset mid-burst or in HOLD: partial accumulation is discarded, out_valid drops immediately, all registers take reset values.
- in_last on a beat that also hits MAX_BEATS: treat as a normal last beat, out_trunc=0.

Optional Feature:
BITWISE_ACCUM_INVERT_EN:
- Defined:
  - in_op widens to 3 bits; bit 2, latched on the first beat, inverts the final result at HOLD entry.
  - This gives NAND/NOR/XNOR/NOT-PASS.
  - Inversion applies once to the final value, not per beat.
  - With bit 2 set, a single-beat burst outputs ~in_data.
- Undefined: in_op is 2 bits and no inversion logic exists.

Test Plan:
- Reset, then burst OR {188899668, 1 last} -> out_valid=1 one cycle after the last beat, out_data=188899669, out_count=2, out_trunc=0.
- Bursts {3678, 2569 last} with AND, OR, XOR -> 2568, 3679, 1111 respectively. in_op changed on beat 2 must have no effect.
- OR burst of 16 beats (1<<i for i=0..15) with in_last never set, MAX_BEATS=16 -> out_data=0x0000FFFF, out_count=16, out_trunc=1, and in_ready=0 in HOLD.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> out_data stays stable and no beats are accepted. Raise out_ready -> drain, and the next burst is accepted the following cycle.
- Bubbles: XOR {0xFFFF0000, idle 3 cycles, 0x00FFFF00 last} -> out_data=0xFF00FF00. Assert reset_n=0 mid-burst -> out_valid=0 and out_data=0 immediately, and the next burst's result is unaffected by the old one.
- With BITWISE_ACCUM_INVERT_EN: op=3'b101 on {3678, 2569 last} -> out_data=~32'd3679=32'hFFFFF1A0.
